audio_sample_feeder: RTL

- Upstream stage of the sigma-delta audio DAC; supplies its `pcm` and `sample_clock` inputs.
- Accepts signed two's-complement samples from the CPU/synth side over a valid/ready handshake and buffers them in a small FIFO.
- Generates the sample-rate strobe from a programmable divider. On each strobe it pops one sample and presents it as offset-binary PCM to the DAC.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_sync_fifo.sv | 61 ++++++
 rtl/audio_sample_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample types, constants and the signed-to-offset-binary helper for the audio feeder
package audio_pkg;

   localparam int AUDIO_BITDEPTH = 12;

   typedef logic signed [AUDIO_BITDEPTH-1:0] sample_t;

   // Offset-binary code for a zero-amplitude sample (DAC output at half scale)
   localparam logic [AUDIO_BITDEPTH-1:0] AUDIO_MIDSCALE = {1'b1, {(AUDIO_BITDEPTH-1){1'b0}}};

   // Two's complement to offset binary is a flip of the sign bit; bits is the sample width
   function automatic logic [31:0] signed_to_offset(input logic [31:0] d, input int unsigned bits);
      return d ^ (32'd1 << (bits - 1));
   endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// rtl/audio_sync_fifo.sv - synchronous FIFO with combinational head, full/empty flags and occupancy count
module audio_sync_fifo #(
   parameter int  WIDTH = 12,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [LW-1:0]    lvl_q, lvl_d;

   // Caller guarantees no push when full and no pop when empty; pointers wrap by power-of-two overflow
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
         2'b10:   lvl_d = lvl_q + 1'b1;
         2'b01:   lvl_d = lvl_q - 1'b1;
         default: lvl_d = lvl_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   // Sample storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wdata;
   end

   assign rdata = mem_q[rd_q];
   assign full  = (lvl_q == LW'(DEPTH));
   assign empty = (lvl_q == '0);
   assign level = lvl_q;

endmodule

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - buffers CPU samples and feeds offset-binary PCM plus sample strobe to the DAC (volume option: AUDIO_SAMPLE_FEEDER_VOLUME_EN)
module audio_sample_feeder
   import audio_pkg::*;
#(
   parameter int  BITDEPTH   = AUDIO_BITDEPTH,
   parameter int  FIFO_DEPTH = 16,
   parameter int  DIV_WIDTH  = 16,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] divider,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BITDEPTH-1:0]  in_data,
   input  logic                 clr_underrun,
`ifdef AUDIO_SAMPLE_FEEDER_VOLUME_EN
   input  logic [7:0]           volume,
`endif
   output logic [BITDEPTH-1:0]  pcm,
   output logic                 sample_clock,
   output logic [LW-1:0]        fifo_level,
   output logic                 underrun
);

   localparam logic [BITDEPTH-1:0] PCM_MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};

   logic [DIV_WIDTH-1:0]       cnt_q, cnt_d;
   logic                       tick;
   logic                       tick_q;
   logic                       sclk_q;
   logic [BITDEPTH-1:0]        pcm_q, pcm_d;
   logic                       und_q, und_d;
   logic                       fifo_full, fifo_empty;
   logic                       push, pop;
   logic [BITDEPTH-1:0]        head;
   logic signed [BITDEPTH-1:0] scaled;

   // Tick fires while the counter sits at zero, so the first one follows reset release immediately
   assign tick     = (cnt_q == '0) && (divider != '0);
   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;
   assign pop      = tick && !fifo_empty;

   // Down-counter reloaded from divider on each tick; a stopped divider parks it at zero
   always_comb begin
      cnt_d = cnt_q;
      if (divider == '0) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = divider;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

`ifdef AUDIO_SAMPLE_FEEDER_VOLUME_EN
   logic [8:0]                 gain;
   logic signed [BITDEPTH+8:0] product;

   // Gain is clamped to unity (128) and applied as a signed multiply with arithmetic /128
   always_comb begin
      gain    = (volume > 8'd128) ? 9'd128 : {1'b0, volume};
      product = $signed(head) * $signed(gain);
      scaled  = BITDEPTH'(product >>> 7);
   end
`else
   assign scaled = head;
`endif

   // New PCM only when a sample was actually popped; an empty tick holds the last value
   always_comb begin
      pcm_d = pcm_q;
      if (pop) pcm_d = BITDEPTH'(signed_to_offset(32'(scaled), BITDEPTH));
   end

   // Sticky underrun: an empty tick wins over a clear in the same cycle
   always_comb begin
      und_d = und_q;
      if (tick && fifo_empty) begin
         und_d = 1'b1;
      end else if (clr_underrun) begin
         und_d = 1'b0;
      end
   end

   // Strobe lags the PCM update by one cycle so the DAC sees settled data on its capture edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sclk_q <= 1'b0;
         pcm_q  <= PCM_MIDSCALE;
         und_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick;
         sclk_q <= tick_q;
         pcm_q  <= pcm_d;
         und_q  <= und_d;
      end
   end

   audio_sync_fifo #(
      .WIDTH (BITDEPTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push),
      .wdata (in_data),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign pcm          = pcm_q;
   assign sample_clock = sclk_q;
   assign underrun     = und_q;

endmodule
